// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: 32 shift-add or restoring shift-subtract steps on magnitudes,
// then one cycle of sign correction into the architectural hi/lo registers.
module muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic         we_hi,
  input  logic         we_lo,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  localparam logic [5:0] LAST = 6'(W - 1);

  function automatic logic [W-1:0] cneg(input logic [W-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*W-1:0] cneg2(input logic [2*W-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  state_e         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           div_q, div_d;
  logic           s1_q, s1_d, s2_q, s2_d;
  logic           dz_q, dz_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d;

  logic           a_neg, b_neg;
  logic [W:0]     mul_sum;
  logic [W:0]     div_sh;
  logic           div_ge;
  logic [W-1:0]   div_rem;

  // op[0]=0 selects the signed flavour of both mult and div
  assign a_neg = ~op[0] & in1[W-1];
  assign b_neg = ~op[0] & in2[W-1];

  // acc_hi:acc_lo is the product shifting right for mult, remainder:dividend shifting left for div
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
  assign div_sh  = {acc_hi_q, acc_lo_q[W-1]};
  assign div_ge  = div_sh >= {1'b0, b_q};
  assign div_rem = div_sh[W-1:0] - b_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          div_d    = op[1];
          s1_d     = a_neg;
          s2_d     = b_neg;
          dz_d     = op[1] & (in2 == '0);
          acc_hi_d = '0;
          acc_lo_d = cneg(in1, a_neg);
          b_d      = cneg(in2, b_neg);
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d = S_IDLE;
          if (we_hi) hi_d = wdata;
          if (we_lo) lo_d = wdata;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (div_q) begin
          acc_hi_d = div_ge ? div_rem : div_sh[W-1:0];
          acc_lo_d = {acc_lo_q[W-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[W:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
        end
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        // a zero divisor leaves the dividend magnitude in acc_hi, so the remainder path restores in1
        if (div_q) begin
          lo_d = dz_q ? '1 : cneg(acc_lo_q, s1_q ^ s2_q);
          hi_d = cneg(acc_hi_q, s1_q);
        end else begin
          {hi_d, lo_d} = cneg2({acc_hi_q, acc_lo_q}, s1_q ^ s2_q);
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_hi_q <= acc_hi_d;
    acc_lo_q <= acc_lo_d;
    b_q      <= b_d;
  end

  assign busy = (state_q == S_RUN) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: W, 32, operand/result width; only W=32 is verified.
REQ-002 SHALL have one clock; reset is synchronous and active-low. Ports in order below.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  launch request; sampled on rising clk.
REQ-006 op  input  2  00 mult signed, 01 multu, 10 div signed, 11 divu.
REQ-007 in1  input  W  multiplicand / dividend.
REQ-008 in2  input  W  multiplier / divisor.
REQ-009 we_hi  input  1  direct write of hi (mthi).
REQ-010 we_lo  input  1  direct write of lo (mtlo).
REQ-011 wdata  input  W  data for we_hi/we_lo.
REQ-012 busy  output  1  operation in progress.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 hi  output  W  product high word / remainder.
REQ-015 lo  output  W  product low word / quotient.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> FIX -> DONE -> IDLE, with outputs hi/lo driven from registers.
REQ-017 IDLE: start=1 SHALL latch op, |in1|, |in2| (signed ops, unsigned magnitudes) and the operand signs, clear the 6-bit iteration counter, and go to RUN.
REQ-018 RUN SHALL perform one shift-add (mult) or restoring shift-subtract (div) step per cycle for exactly W=32 cycles, then go to FIX.
REQ-019 FIX (1 cycle) SHALL apply sign correction and write hi/lo at the end of the cycle, then go to DONE.
REQ-020 Latency: with start sampled at end of cycle 0, busy=1 in cycles 1..33, done=1 and busy=0 in cycle 34, and new hi/lo visible from cycle 34.
REQ-021 DONE SHALL behave as IDLE for start, so back-to-back operations issue every 34 cycles.
REQ-022 start while busy=1 SHALL be ignored with no effect on the operation in flight.
REQ-023 Signed mult: the 64-bit product is negated iff the operand signs differ; {hi,lo} = full two's-complement 64-bit product.
REQ-024 Signed div: quotient is negated iff the signs differ; remainder takes the sign of the dividend (truncating division).
REQ-025 Divide by zero (any div op) SHALL give lo=32'hFFFFFFFF, hi=in1, with normal latency.
REQ-026 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-027 we_hi/we_lo SHALL update hi/lo from wdata at the clock edge, only in IDLE/DONE with start=0; both may write in the same cycle.
REQ-028 we_hi/we_lo SHALL be ignored while busy=1, or when start=1 in the same cycle (start has priority).
REQ-029 hi/lo SHALL hold their values between operations and SHALL NOT change during RUN.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0, and counter=0.
REQ-031 Reset mid-operation SHALL abort the operation; no done pulse and no hi/lo update follow.
REQ-032 start or we_* sampled in the same edge as rst_n=0 SHALL be ignored.

Verification
REQ-033 multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly in cycle 34 after start.
REQ-034 mult -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 100/7 -> lo=14, hi=2.
REQ-035 divu 100/0 -> lo=0xFFFFFFFF, hi=0x00000064; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 Second start at cycle 5 with different operands -> ignored; first result intact at cycle 34; start during the done cycle -> next done at cycle 68.
REQ-037 rst_n=0 at cycle 10 of an operation -> busy=0, hi=lo=0 next cycle; no done pulse for the following 40 cycles.
REQ-038 we_hi=1, wdata=0x12345678 while idle -> hi=0x12345678; the same write while busy -> hi unchanged.
